// File: rtl/sm83_flags_pkg.sv
// Shared types and flag bit positions for the SM83 flag unit.
// Used by sm83_flags_unit and sm83_flags_stack (optional SM83_FLAGS_ERR_EN feature).
package sm83_flags_pkg;

  // Flag bit positions inside a WORD_SIZE-wide F register image
  function automatic int unsigned z_idx(input int unsigned ws);
    return ws - 1;
  endfunction

  function automatic int unsigned n_idx(input int unsigned ws);
    return ws - 2;
  endfunction

  function automatic int unsigned h_idx(input int unsigned ws);
    return ws - 3;
  endfunction

  function automatic int unsigned c_idx(input int unsigned ws);
    return ws - 4;
  endfunction

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flag_ctx_t;

  typedef enum logic [1:0] {
    SEC_SRC_CARRY = 2'b00,
    SEC_SRC_SHIFT = 2'b01,
    SEC_SRC_DAA   = 2'b10,
    SEC_SRC_ZERO  = 2'b11
  } sec_src_e;

endpackage

// File: rtl/sm83_flags_stack.sv
// LIFO of saved flag contexts with push, pop and exchange.
// SM83_FLAGS_ERR_EN adds a sticky overflow/underflow flag.
module sm83_flags_stack
  import sm83_flags_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_push,
  input  logic      i_pop,
  input  flag_ctx_t i_ctx,
  output flag_ctx_t o_ctx,
  output logic      o_load,
  output logic      o_empty,
  output logic      o_full
`ifdef SM83_FLAGS_ERR_EN
  ,
  output logic      o_err
`endif
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]  r_sp;
  flag_ctx_t        r_mem [STACK_DEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_xchg;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  // push+pop on an empty stack degrades to a plain push
  assign w_xchg    = i_push & i_pop & ~w_empty;
  assign w_push    = i_push & ~w_xchg & ~w_full;
  assign w_pop     = i_pop & ~i_push & ~w_empty;
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign w_wr_idx  = w_xchg ? w_top_idx : IDX_W'(r_sp);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Contents survive reset; only the pointer is cleared
  always_ff @(posedge i_clk) begin
    if (!i_reset && (w_push || w_xchg)) begin
      r_mem[w_wr_idx] <= i_ctx;
    end
  end

  assign o_ctx   = r_mem[w_top_idx];
  assign o_load  = w_xchg | w_pop;
  assign o_empty = w_empty;
  assign o_full  = w_full;

`ifdef SM83_FLAGS_ERR_EN
  logic r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if ((i_push & ~i_pop & w_full) | (i_pop & ~i_push & w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: rtl/sm83_flags_unit.sv
// SM83 flag register (Z/N/H/C, DAA and secondary carry) with a hardware flag-context stack.
// Define SM83_FLAGS_ERR_EN to expose the sticky o_stack_err output.
module sm83_flags_unit
  import sm83_flags_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WORD_SIZE-1:0] i_din,
  output logic [WORD_SIZE-1:0] o_dout,
  input  logic                 i_flags_bus,
  input  logic                 i_flags_alu,
  input  logic                 i_zero_we,
  input  logic                 i_zero_loop,
  input  logic                 i_half_carry_we,
  input  logic                 i_half_carry_cpl,
  input  logic                 i_daa_carry_we,
  input  logic                 i_neg_we,
  input  logic                 i_neg_set,
  input  logic                 i_neg_clr,
  input  logic                 i_carry_we,
  input  logic                 i_sec_carry_we,
  input  logic                 i_sec_carry_sh,
  input  logic                 i_sec_carry_daa,
  input  logic                 i_sec_carry_sel,
  input  logic                 i_carry_set,
  input  logic                 i_carry_cpl,
  input  logic                 i_zero_in,
  input  logic                 i_carry_in,
  input  logic                 i_shift_out_in,
  input  logic                 i_daa_carry_in,
  input  logic                 i_push,
  input  logic                 i_pop,
  output logic                 o_zero,
  output logic                 o_half_carry,
  output logic                 o_daa_carry,
  output logic                 o_neg,
  output logic                 o_carry,
  output logic                 o_pri_carry,
  output logic                 o_stack_empty,
  output logic                 o_stack_full
`ifdef SM83_FLAGS_ERR_EN
  ,
  output logic                 o_stack_err
`endif
);

  localparam int unsigned ZI = z_idx(WORD_SIZE);
  localparam int unsigned NI = n_idx(WORD_SIZE);
  localparam int unsigned HI = h_idx(WORD_SIZE);
  localparam int unsigned CI = c_idx(WORD_SIZE);

  logic                 r_z;
  logic                 r_n;
  logic                 r_h;
  logic                 r_pri_c;
  logic                 r_daa_c;
  logic                 r_sec_c;
  logic                 w_z_new;
  logic                 w_n_new;
  logic                 w_h_src;
  logic                 w_c_src;
  logic                 w_sec_src;
  logic                 w_load;
  logic                 w_half;
  logic                 w_carry;
  logic                 w_unused_din;
  flag_ctx_t            w_live_ctx;
  flag_ctx_t            w_pop_ctx;
  logic [WORD_SIZE-1:0] w_dout;

  // Flag sources; exactly one of bus/alu is high while any write strobe is active
  assign w_z_new = ((i_flags_bus & i_din[ZI]) | (i_flags_alu & i_zero_in)) & (~i_zero_loop | r_z);
  assign w_n_new = ~i_neg_clr & (i_neg_set | (i_flags_bus & i_din[NI]));
  assign w_h_src = (i_flags_bus & i_din[HI]) | (i_flags_alu & i_carry_in);
  assign w_c_src = (i_flags_bus & i_din[CI]) | (i_flags_alu & i_carry_in);
  assign w_unused_din = ^i_din;

  always_comb begin
    w_sec_src = 1'b0;
    case (sec_src_e'({i_sec_carry_daa, i_sec_carry_sh}))
      SEC_SRC_CARRY: w_sec_src = i_carry_in;
      SEC_SRC_SHIFT: w_sec_src = i_shift_out_in;
      SEC_SRC_DAA:   w_sec_src = i_daa_carry_in;
      SEC_SRC_ZERO:  w_sec_src = 1'b0;
    endcase
  end

  assign w_live_ctx = '{z: r_z, n: r_n, h: r_h, c: r_pri_c};

  sm83_flags_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_push),
    .i_pop   (i_pop),
    .i_ctx   (w_live_ctx),
    .o_ctx   (w_pop_ctx),
    .o_load  (w_load),
    .o_empty (o_stack_empty),
    .o_full  (o_stack_full)
`ifdef SM83_FLAGS_ERR_EN
    ,
    .o_err   (o_stack_err)
`endif
  );

  // A restored context overrides the architectural flag strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_h     <= 1'b0;
      r_pri_c <= 1'b0;
      r_daa_c <= 1'b0;
      r_sec_c <= 1'b0;
    end else begin
      if (w_load) begin
        r_z     <= w_pop_ctx.z;
        r_n     <= w_pop_ctx.n;
        r_h     <= w_pop_ctx.h;
        r_pri_c <= w_pop_ctx.c;
      end else begin
        if (i_zero_we)                      r_z     <= w_z_new;
        if (i_neg_we)                       r_n     <= w_n_new;
        if (i_half_carry_we)                r_h     <= w_h_src;
        if (i_carry_we && !i_sec_carry_we)  r_pri_c <= w_c_src;
      end
      if (i_daa_carry_we) r_daa_c <= w_h_src;
      if (i_sec_carry_we) r_sec_c <= w_sec_src;
    end
  end

  assign w_half  = r_h ^ i_half_carry_cpl;
  assign w_carry = (i_carry_set | (i_sec_carry_sel ? r_sec_c : r_pri_c)) ^ i_carry_cpl;

  always_comb begin
    w_dout     = '0;
    w_dout[ZI] = r_z;
    w_dout[NI] = r_n;
    w_dout[HI] = w_half;
    w_dout[CI] = w_carry;
  end

  assign o_dout       = w_dout;
  assign o_zero       = r_z;
  assign o_neg        = r_n;
  assign o_half_carry = w_half;
  assign o_carry      = w_carry;
  assign o_daa_carry  = r_daa_c;
  assign o_pri_carry  = r_pri_c;

endmodule

// File: doc/sm83_flags_unit.md
# sm83_flags_unit

Parametrised successor to the SM83 ALU flag register: holds Z/N/H/C plus the DAA half-carry and secondary-carry registers, and adds a hardware flag-context stack, so the core can save and restore flags on interrupt entry/exit without a bus round-trip. Sits beside the ALU in the CPU datapath. The control unit drives its write strobes, and its flag outputs feed the ALU carry-in, the condition-code logic and the F-register bus path.

## Interface
- WORD_SIZE, 8: bus width. Flags occupy the top 4 bits: Z=WS-1, N=WS-2, H=WS-3, C=WS-4. Lower bits read 0. Must be ≥4.
- STACK_DEPTH, 4: flag-context entries. Must be ≥1.
- clk  in  1  clock. Everything is posedge. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- din / dout  in/out  WORD_SIZE  flags from/to data bus.
- flags_bus, flags_alu  in  1  source select. Exactly one is high whenever any flag write strobe is high.
- zero_we, zero_loop, half_carry_we, half_carry_cpl, daa_carry_we, neg_we, neg_set, neg_clr, carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl  in  1  flag controls.
- zero_in, carry_in, shift_out_in, daa_carry_in  in  1  ALU-side flag sources.
- push, pop  in  1  save/restore the architectural flag context.
- zero, half_carry, daa_carry, neg, carry, pri_carry  out  1  flag outputs.
- stack_empty, stack_full  out  1  stack status.
- stack_err  out  1  sticky overflow/underflow (present only with SM83_FLAGS_ERR_EN).

## Operation
- Flag writes, all registered:
  - Z: new = din[Z] (bus) or zero_in (alu). zero_loop ANDs new with the current Z.
  - N: neg_set OR (flags_bus & din[N]). neg_clr forces 0.
  - H/daa_carry/pri_carry: din[H]/din[H]/din[C] (bus) or carry_in (alu).
  - pri_carry updates only when carry_we & !sec_carry_we.
  - sec_c from {sec_carry_daa, sec_carry_sh}: 00 carry_in, 01 shift_out_in, 10 daa_carry_in, 11 → 0.
- Outputs, combinational from registers:
  - carry = carry_set | (sec_carry_sel ? sec_c : pri_carry), then inverted if carry_cpl.
  - half_carry = H ^ half_carry_cpl.
  - dout packs zero/neg/half_carry/carry.
- Context entry = {Z, N, H, pri_carry}, 4 bits. daa_carry and sec_c are never stacked.
- push (not full): writes the current registered context to stack[sp], then sp+1. Same-cycle flag writes still update the live registers.
- pop (not empty): sp-1, then loads Z/N/H/pri_carry from stack[sp-1]. Pop overrides any same-cycle zero_we/neg_we/half_carry_we/carry_we. daa_carry_we and sec_carry_we still apply.
- push & pop together, not empty: exchange. The live context goes into the top entry, the top entry goes live, and sp is unchanged. When empty, treat as push alone.
- push when full: ignored, sp stays STACK_DEPTH. pop when empty: ignored, live flags written normally.
- sp range 0..STACK_DEPTH. Width $clog2(STACK_DEPTH+1). No wrap-around.
- stack_empty = (sp==0). stack_full = (sp==STACK_DEPTH).

## Timing
- Reset (sync, takes precedence over all strobes):
  - All flag regs, sec_c, daa_carry, sp and stack_err clear to 0.
  - Stack contents are not cleared.
  - Outputs after reset: zero=neg=half_carry=daa_carry=pri_carry=0. carry=carry_set^carry_cpl. stack_empty=1, stack_full=0.
- Write latency 1 cycle: a strobe at edge n is visible on outputs after edge n.
- Pop latency 1 cycle. A push and an immediately following pop restore the exact pushed context.
- Control-to-carry/half_carry path is combinational, 0 cycles.

## Configuration
- SM83_FLAGS_ERR_EN defined:
  - stack_err port exists.
  - Set on push-when-full or pop-when-empty (exchange excluded). Cleared only by reset.
- SM83_FLAGS_ERR_EN undefined:
  - Port and register absent.
  - Illegal push/pop is silently ignored exactly as above.

## Structure
- Package sm83_flags_pkg:
  - Flag index localparams as functions of WORD_SIZE.
  - Packed struct flag_ctx_t {z, n, h, c}.
  - Enum for the sec-carry source select.
- Sub-module sm83_flags_stack:
  - Parametrised LIFO of flag_ctx_t, STACK_DEPTH entries.
  - Has push/pop/exchange, sp, empty/full, and the optional error.
  - The top level instantiates it once.

## Test plan
- Reset after arbitrary writes → all flags 0, stack_empty=1. With carry_cpl=1 → carry=1.
- Bus write din=8'hF0 with all we + flags_bus → next cycle dout=8'hF0. Then alu write with zero_loop=1, zero_in=1 → Z stays 1.
- Push ctx 4'b1010, write flags to 4'b0101, pop → dout=8'hA0. Same-cycle carry_we during pop is ignored.
- Fill to STACK_DEPTH=4, then push a 5th → stack_full=1, sp unchanged, stack_err=1 (ERR_EN). Four pops return entries in LIFO order, then stack_empty=1.
- Pop when empty with neg_we, neg_set=1 → N=1, sp=0, stack_err=1 (ERR_EN), no err without the macro.
- Simultaneous push+pop with top=4'b1100, live=4'b0011 → live=4'b1100, top=4'b0011, sp unchanged.
